// File: rtl/sync_gen_param.sv
// sync_gen_param: parametrised VESA-style sync generator.
// Produces H/V sync, display enable, pixel coordinates and line/frame start
// strobes for any video mode. All outputs are registered from the counter
// values of the same ce cycle, so they lag the counters by one ce cycle.
// Optional feature macro: SYNC_GEN_PREFETCH_EN adds a prefetch window
// (fetch_area/fetch_x) that leads the display area by PREFETCH_LEAD pixels.
// Without the macro, fetch_area and fetch_x are tied to zero.
module sync_gen_param #(
  parameter int H_VISIBLE     = 1280,
  parameter int H_FRONT       = 48,
  parameter int H_SYNC        = 112,
  parameter int H_BACK        = 248,
  parameter int V_VISIBLE     = 1024,
  parameter int V_FRONT       = 1,
  parameter int V_SYNC        = 3,
  parameter int V_BACK        = 38,
  parameter int H_POL         = 1,
  parameter int V_POL         = 1,
  parameter int CW            = 11,
  parameter int PREFETCH_LEAD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  output logic          vga_h_sync,
  output logic          vga_v_sync,
  output logic          inDisplayArea,
  output logic [CW-1:0] CounterX,
  output logic [CW-1:0] CounterY,
  output logic          line_start,
  output logic          frame_start,
  output logic          fetch_area,
  output logic [CW-1:0] fetch_x
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic          H_ACT    = (H_POL != 0);
  localparam logic          V_ACT    = (V_POL != 0);

  // Elaboration-time sanity checks on the mode parameters.
  if ((H_TOTAL - 1) >= (1 << CW)) begin : g_h_width_err
    $error("sync_gen_param: CW too small for H_TOTAL-1");
  end
  if ((V_TOTAL - 1) >= (1 << CW)) begin : g_v_width_err
    $error("sync_gen_param: CW too small for V_TOTAL-1");
  end
  if ((PREFETCH_LEAD < 1) || (PREFETCH_LEAD > H_FRONT + H_SYNC + H_BACK)) begin : g_lead_err
    $error("sync_gen_param: PREFETCH_LEAD out of range");
  end

  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;

  logic          h_sync_q, h_sync_d;
  logic          v_sync_q, v_sync_d;
  logic          de_q, de_d;
  logic [CW-1:0] x_q, y_q;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Next counter position: hc wraps at end of line, vc steps on hc wrap.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (ce) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
      end else begin
        hc_d = hc_q + CW'(1);
      end
    end
  end

  // Decode the current counter position into the next output values.
  always_comb begin
    h_sync_d      = ((hc_q >= HS_START) && (hc_q < HS_END)) ? H_ACT : ~H_ACT;
    v_sync_d      = ((vc_q >= VS_START) && (vc_q < VS_END)) ? V_ACT : ~V_ACT;
    de_d          = (hc_q < H_VIS) && (vc_q < V_VIS);
    line_start_d  = (hc_q == '0);
    frame_start_d = (hc_q == '0) && (vc_q == '0);
  end

  // Counters and registered outputs; everything holds while ce is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      h_sync_q      <= ~H_ACT;
      v_sync_q      <= ~V_ACT;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (ce) begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      de_q          <= de_d;
      x_q           <= hc_q;
      y_q           <= vc_q;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_h_sync    = h_sync_q;
  assign vga_v_sync    = v_sync_q;
  assign inDisplayArea = de_q;
  assign CounterX      = x_q;
  assign CounterY      = y_q;
  assign line_start    = line_start_q;
  assign frame_start   = frame_start_q;

`ifdef SYNC_GEN_PREFETCH_EN
  localparam logic [CW:0] LEAD_W  = (CW+1)'(PREFETCH_LEAD);
  localparam logic [CW:0] H_TOT_W = (CW+1)'(H_TOTAL);

  logic [CW:0]   h_sum;
  logic [CW-1:0] hl, vl;
  logic          fetch_area_q;
  logic [CW-1:0] fetch_x_q;

  // Look-ahead position LEAD pixels ahead; the lead never exceeds one line,
  // so at most one horizontal wrap (and one line step) is needed.
  always_comb begin
    h_sum = {1'b0, hc_q} + LEAD_W;
    if (h_sum >= H_TOT_W) begin
      hl = CW'(h_sum - H_TOT_W);
      vl = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
    end else begin
      hl = h_sum[CW-1:0];
      vl = vc_q;
    end
  end

  // Prefetch window registered with the same alignment as the display area.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_area_q <= 1'b0;
      fetch_x_q    <= '0;
    end else if (ce) begin
      fetch_area_q <= (hl < H_VIS) && (vl < V_VIS);
      fetch_x_q    <= hl;
    end
  end

  assign fetch_area = fetch_area_q;
  assign fetch_x    = fetch_x_q;
`else
  assign fetch_area = 1'b0;
  assign fetch_x    = '0;
`endif

endmodule

// File: tb/tb_sync_gen_param.sv
// tb_sync_gen_param: three instances (small positive-polarity mode, small
// negative-polarity mode, default 1280x1024 mode) driven by shared clk,
// rst_n and ce, checked against a linear-position reference model.
module tb_sync_gen_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;

  // clock block
  always #5 clk = ~clk;

  logic       p_hs, p_vs, p_de, p_ls, p_fs, p_fa;
  logic [4:0] p_x, p_y, p_fx;
  logic       n_hs, n_vs, n_de, n_ls, n_fs, n_fa;
  logic [4:0] n_x, n_y, n_fx;
  logic        d_hs, d_vs, d_de, d_ls, d_fs, d_fa;
  logic [10:0] d_x, d_y, d_fx;

  sync_gen_param #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(1), .V_POL(1), .CW(5), .PREFETCH_LEAD(4)
  ) dut_pos (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .vga_h_sync(p_hs), .vga_v_sync(p_vs), .inDisplayArea(p_de),
    .CounterX(p_x), .CounterY(p_y), .line_start(p_ls), .frame_start(p_fs),
    .fetch_area(p_fa), .fetch_x(p_fx)
  );

  sync_gen_param #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(0), .V_POL(0), .CW(5), .PREFETCH_LEAD(4)
  ) dut_neg (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .vga_h_sync(n_hs), .vga_v_sync(n_vs), .inDisplayArea(n_de),
    .CounterX(n_x), .CounterY(n_y), .line_start(n_ls), .frame_start(n_fs),
    .fetch_area(n_fa), .fetch_x(n_fx)
  );

  sync_gen_param dut_def (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .vga_h_sync(d_hs), .vga_v_sync(d_vs), .inDisplayArea(d_de),
    .CounterX(d_x), .CounterY(d_y), .line_start(d_ls), .frame_start(d_fs),
    .fetch_area(d_fa), .fetch_x(d_fx)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int n_ce = 0;  // ce cycles accepted since the last reset release

  typedef struct packed {
    logic        hs, vs, de, ls, fs, fa;
    logic [31:0] x, y, fx;
  } exp_t;

  // Reference model: the n-th ce cycle after reset shows linear frame
  // position n-1; column/line follow from plain division.
  function automatic exp_t model(input int hv, hf, hsw, hb, vv, vf, vsw, vb,
                                 input logic hp, vp, input int lead, input int n);
    exp_t e;
    int ht, vt, fr, p, x, y, q;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    fr = ht * vt;
    e = '0;
    e.hs = ~hp;
    e.vs = ~vp;
    if (n == 0) return e;
    p = (n - 1) % fr;
    x = p % ht;
    y = p / ht;
    e.hs = (x >= hv + hf && x < hv + hf + hsw) ? hp : ~hp;
    e.vs = (y >= vv + vf && y < vv + vf + vsw) ? vp : ~vp;
    e.de = (x < hv) && (y < vv);
    e.x  = 32'(x);
    e.y  = 32'(y);
    e.ls = (x == 0);
    e.fs = (p == 0);
`ifdef SYNC_GEN_PREFETCH_EN
    q = (p + lead) % fr;
    e.fa = ((q % ht) < hv) && ((q / ht) < vv);
    e.fx = 32'(q % ht);
`else
    q = lead;
    e.fa = 1'b0;
    e.fx = 32'(q - q);
`endif
    return e;
  endfunction

  // scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d (n_ce=%0d)", tag, obs, exp, n_ce);
    end
  endtask

  task automatic chk_dut(input string t, input exp_t e,
                         input logic hs, vs, de, ls, fs, fa,
                         input logic [31:0] x, y, fx);
    chk({t, ".hs"}, 32'(hs), 32'(e.hs));
    chk({t, ".vs"}, 32'(vs), 32'(e.vs));
    chk({t, ".de"}, 32'(de), 32'(e.de));
    chk({t, ".x"}, x, e.x);
    chk({t, ".y"}, y, e.y);
    chk({t, ".ls"}, 32'(ls), 32'(e.ls));
    chk({t, ".fs"}, 32'(fs), 32'(e.fs));
    chk({t, ".fa"}, 32'(fa), 32'(e.fa));
    chk({t, ".fx"}, fx, e.fx);
  endtask

  task automatic check_all();
    chk_dut("pos", model(8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1, 4, n_ce),
            p_hs, p_vs, p_de, p_ls, p_fs, p_fa, 32'(p_x), 32'(p_y), 32'(p_fx));
    chk_dut("neg", model(8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0, 4, n_ce),
            n_hs, n_vs, n_de, n_ls, n_fs, n_fa, 32'(n_x), 32'(n_y), 32'(n_fx));
    chk_dut("def", model(1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1, 1'b1, 16, n_ce),
            d_hs, d_vs, d_de, d_ls, d_fs, d_fa, 32'(d_x), 32'(d_y), 32'(d_fx));
  endtask

  // driver: drive ce at the falling edge, sample after the next falling edge
  task automatic step(input logic ce_v);
    ce = ce_v;
    @(posedge clk);
    if (rst_n && ce_v) n_ce++;
    @(negedge clk);
    check_all();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    n_ce = 0;
    check_all();
    step(1'b1);
    rst_n = 1'b1;
  endtask

  int cnt_hs, cnt_vs, cnt_de, cnt_fs, cnt_nhs;
  int rises, first_rise, second_rise;
  logic prev;

  initial begin
    // reset state
    @(negedge clk);
    check_all();
    step(1'b0);
    step(1'b1);
    rst_n = 1'b1;
    step(1'b0);
    step(1'b0);

    // two full small-mode frames with ce held high
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_fs = 0; cnt_nhs = 0;
    for (int i = 0; i < 256; i++) begin
      step(1'b1);
      cnt_hs  += int'(p_hs);
      cnt_vs  += int'(p_vs);
      cnt_de  += int'(p_de);
      cnt_fs  += int'(p_fs);
      cnt_nhs += int'(!n_hs);
    end
    chk("agg.pos_hs", 32'(cnt_hs), 32'd48);
    chk("agg.pos_vs", 32'(cnt_vs), 32'd64);
    chk("agg.pos_de", 32'(cnt_de), 32'd64);
    chk("agg.pos_fs", 32'(cnt_fs), 32'd2);
    chk("agg.neg_hs_low", 32'(cnt_nhs), 32'd48);

    // ce toggling: frame period doubles to 256 clk
    rises = 0; first_rise = 0; second_rise = 0;
    prev = p_fs;
    for (int i = 0; i < 512; i++) begin
      step((i % 2) == 0);
      if (p_fs && !prev) begin
        rises++;
        if (rises == 1) first_rise = i;
        if (rises == 2) second_rise = i;
      end
      prev = p_fs;
    end
    chk("tog.fs_rises", 32'(rises), 32'd2);
    chk("tog.fs_period", 32'(second_rise - first_rise), 32'd256);

    // asynchronous reset in the middle of line 2
    reset_pulse();
    for (int i = 0; i < 37; i++) step(1'b1);
    chk("mid.pre_x", 32'(p_x), 32'd4);
    chk("mid.pre_y", 32'(p_y), 32'd2);
    rst_n = 1'b0;
    #1;
    n_ce = 0;
    check_all();
    chk("mid.async_de", 32'(p_de), 32'd0);
    step(1'b1);
    step(1'b1);
    rst_n = 1'b1;
    step(1'b1);
    chk("mid.fs_after", 32'(p_fs), 32'd1);
    chk("mid.de_after", 32'(p_de), 32'd1);

    // random ce with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) reset_pulse();
      step(1'($urandom_range(0, 1)));
    end

    // default mode: first visible pixel and h_sync period
    reset_pulse();
    step(1'b1);
    chk("def.first_de", 32'(d_de), 32'd1);
    chk("def.first_x", 32'(d_x), 32'd0);
    rises = 0; first_rise = 0; second_rise = 0;
    prev = d_hs;
    for (int i = 0; i < 1688 * 2 + 50; i++) begin
      step(1'b1);
      if (d_hs && !prev) begin
        rises++;
        if (rises == 1) first_rise = i;
        if (rises == 2) second_rise = i;
      end
      prev = d_hs;
    end
    chk("def.hs_rises", 32'(rises), 32'd2);
    chk("def.hs_period", 32'(second_rise - first_rise), 32'd1688);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
